// File: rtl/count_capture.sv
// Input-capture unit: timestamps selected edges of an async event line with the live timer value into a show-ahead FIFO.
// Optional glitch filter enabled by defining COUNT_CAPTURE_FILTER_EN.
module count_capture #(
  parameter int COUNTER_SIZE = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    edgeMode,
  input  logic [COUNTER_SIZE-1:0]       count_in,
  input  logic                          capture_in,
  output logic [COUNTER_SIZE-1:0]       cap_value,
  output logic                          cap_edge,
  output logic                          cap_valid,
  input  logic                          cap_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          lost,
  input  logic                          clear_lost
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef COUNT_CAPTURE_FILTER_EN
  localparam int ARM_MAX = SYNC_STAGES + 3;
`else
  localparam int ARM_MAX = SYNC_STAGES + 1;
`endif
  localparam int ARM_W = $clog2(ARM_MAX + 1);

  function automatic logic [ARM_W-1:0] arm_sat_inc(input logic [ARM_W-1:0] v);
    if (v == ARM_W'(ARM_MAX)) return v;
    return v + ARM_W'(1);
  endfunction

  // ---- p0: synchronizer and arming ----
  logic [SYNC_STAGES-1:0] sync_p0;
  logic [ARM_W-1:0]       arm_p0;
  logic                   sync_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      arm_p0  <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], capture_in};
      arm_p0  <= arm_sat_inc(arm_p0);
    end
  end

  assign sync_out = sync_p0[SYNC_STAGES-1];

  // ---- p1: optional filter and edge detection ----
  logic lvl;
  logic lvl_prev;

`ifdef COUNT_CAPTURE_FILTER_EN
  logic hist_a_p1, hist_b_p1, filt_p1;

  // The filtered level follows sync_out once it has agreed over three consecutive cycles.
  always_comb begin
    lvl = filt_p1;
    if ((sync_out == hist_a_p1) && (hist_a_p1 == hist_b_p1)) lvl = sync_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_a_p1 <= 1'b0;
      hist_b_p1 <= 1'b0;
      filt_p1   <= 1'b0;
    end else begin
      hist_a_p1 <= sync_out;
      hist_b_p1 <= hist_a_p1;
      filt_p1   <= lvl;
    end
  end

  assign lvl_prev = filt_p1;
`else
  logic lvl_p1;

  always_ff @(posedge clk) begin
    if (reset) lvl_p1 <= 1'b0;
    else       lvl_p1 <= sync_out;
  end

  assign lvl      = sync_out;
  assign lvl_prev = lvl_p1;
`endif

  logic                  armed;
  logic                  rising, falling;
  logic                  vld_p1;
  logic [COUNTER_SIZE:0] stamp_p1;

  assign armed    = (arm_p0 == ARM_W'(ARM_MAX));
  assign rising   = lvl & ~lvl_prev;
  assign falling  = ~lvl & lvl_prev;
  assign vld_p1   = armed & enable & ((rising & edgeMode[0]) | (falling & edgeMode[1]));
  assign stamp_p1 = {count_in, rising};

  // ---- p2: capture FIFO ----
  logic [COUNTER_SIZE:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full, pop, do_push, drop;
  logic [COUNTER_SIZE:0] head;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign pop     = cap_valid & cap_ready;
  assign do_push = vld_p1 & (~full | pop);
  assign drop    = vld_p1 & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= stamp_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      lost   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // A new drop outranks a coincident clear.
      if (drop)            lost <= 1'b1;
      else if (clear_lost) lost <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr];
  assign cap_valid  = (level != '0);
  assign cap_value  = cap_valid ? head[COUNTER_SIZE:1] : '0;
  assign cap_edge   = cap_valid & head[0];
  assign fifo_level = level;

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: table of single-edge scenarios, hand-written FIFO corner sequences,
// then randomized traffic against a history-based queue model.
module tb_count_capture;

`ifdef COUNT_CAPTURE_FILTER_EN
  localparam int L = 4;
`else
  localparam int L = 2;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  edgeMode = 2'b01;
  logic [31:0] cnt = '0;
  logic        capture_in = 1'b0;
  logic [31:0] cap_value;
  logic        cap_edge;
  logic        cap_valid;
  logic        cap_ready = 1'b1;
  logic [2:0]  fifo_level;
  logic        lost;
  logic        clear_lost = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  count_capture #(.COUNTER_SIZE(32), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .edgeMode(edgeMode),
    .count_in(cnt), .capture_in(capture_in), .cap_value(cap_value),
    .cap_edge(cap_edge), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .fifo_level(fifo_level), .lost(lost), .clear_lost(clear_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 32'd1;

  typedef struct {
    logic [31:0] val;
    logic        edg;
  } ent_t;

  typedef struct {
    logic [1:0] mode;
    logic       en;
    int         start;
    int         len;
    int         n_exp;
    int         v0;
    logic       e0;
    int         v1;
    logic       e1;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input int x);
    int guard;
    guard = 0;
    while (cnt != x && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cnt != x) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cnt: count %0d, expected %0d", cnt, x);
    end
  endtask

  task automatic pulse(input int start, input int len);
    wait_cnt(start);
    capture_in = 1'b1;
    tick(len);
    capture_in = 1'b0;
  endtask

  // Collector for table scenarios: each negedge with valid&ready is one popped entry.
  ent_t got[$];
  bit   collect = 1'b0;
  always @(negedge clk)
    if (collect && cap_valid && cap_ready) got.push_back('{cap_value, cap_edge});

  // Reference model: an edge first sampled L clocks ago becomes an entry stamped with the current count.
  ent_t mq[$];
  logic mlost = 1'b0;
  logic hist[16];
  int   mcyc = 0;
  bit   model_on = 1'b0;
  logic ma, mb, mreq, medge, mdrop;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mlost = 1'b0;
      mcyc  = 0;
      for (int i = 0; i < 16; i++) hist[i] = 1'b0;
    end else begin
      hist[mcyc % 16] = capture_in;
      mreq  = 1'b0;
      medge = 1'b0;
      if (mcyc >= L + 1) begin
        ma = hist[(mcyc - L) % 16];
        mb = hist[(mcyc - L - 1) % 16];
        if (enable && ma && !mb && edgeMode[0]) begin mreq = 1'b1; medge = 1'b1; end
        if (enable && !ma && mb && edgeMode[1]) begin mreq = 1'b1; medge = 1'b0; end
      end
      if (mq.size() > 0 && cap_ready) void'(mq.pop_front());
      mdrop = 1'b0;
      if (mreq) begin
        if (mq.size() < DEPTH) mq.push_back('{cnt, medge});
        else begin mdrop = 1'b1; mlost = 1'b1; end
      end
      if (!mdrop && clear_lost) mlost = 1'b0;
      mcyc++;
    end
  end

  always @(negedge clk) begin
    if (model_on && !reset) begin
      check("rnd_valid", cap_valid, mq.size() != 0);
      check("rnd_level", fifo_level, mq.size());
      check("rnd_lost", lost, mlost);
      if (mq.size() > 0) begin
        check("rnd_value", cap_value, mq[0].val);
        check("rnd_edge", cap_edge, mq[0].edg);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[5];
  int   hold;
  int   exp_drain[4];

  initial begin
    vt[0] = '{2'b01, 1'b1, 100, 20, 1, 100 + L, 1'b1, 0, 1'b0};
    vt[1] = '{2'b11, 1'b1, 200, 50, 2, 200 + L, 1'b1, 250 + L, 1'b0};
    vt[2] = '{2'b10, 1'b1, 300, 10, 1, 310 + L, 1'b0, 0, 1'b0};
    vt[3] = '{2'b00, 1'b1, 350, 10, 0, 0, 1'b0, 0, 1'b0};
    vt[4] = '{2'b11, 1'b0, 400, 10, 0, 0, 1'b0, 0, 1'b0};

    tick(4);
    @(negedge clk);
    check("rst_valid", cap_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_lost", lost, 0);
    check("rst_value", cap_value, 0);
    check("rst_edge", cap_edge, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      edgeMode = vt[i].mode;
      enable   = vt[i].en;
      got.delete();
      collect  = 1'b1;
      pulse(vt[i].start, vt[i].len);
      tick(12);
      collect  = 1'b0;
      check($sformatf("v%0d_count", i), got.size(), vt[i].n_exp);
      if (vt[i].n_exp > 0 && got.size() > 0) begin
        check($sformatf("v%0d_val0", i), got[0].val, vt[i].v0);
        check($sformatf("v%0d_edge0", i), got[0].edg, vt[i].e0);
      end
      if (vt[i].n_exp > 1 && got.size() > 1) begin
        check($sformatf("v%0d_val1", i), got[1].val, vt[i].v1);
        check($sformatf("v%0d_edge1", i), got[1].edg, vt[i].e1);
      end
      @(negedge clk);
      check($sformatf("v%0d_level_end", i), fifo_level, 0);
      enable = 1'b1;
    end

`ifdef COUNT_CAPTURE_FILTER_EN
    cap_ready = 1'b0;
    edgeMode  = 2'b01;
    wait_cnt(450);
    capture_in = 1'b1;
    tick(2);
    capture_in = 1'b0;
    tick(12);
    @(negedge clk);
    check("filt_glitch_level", fifo_level, 0);
`endif

    // Overrun: five rises with the consumer stalled.
    cap_ready = 1'b0;
    edgeMode  = 2'b01;
    for (int k = 0; k < 5; k++) pulse(600 + 10 * k, 5);
    tick(8);
    @(negedge clk);
    check("ovr_level", fifo_level, 4);
    check("ovr_lost", lost, 1);
    check("ovr_head", cap_value, 600 + L);
    check("ovr_edge", cap_edge, 1);

    wait_cnt(660);
    capture_in = 1'b1;
    wait_cnt(660 + L);
    clear_lost = 1'b1;
    tick(1);
    clear_lost = 1'b0;
    @(negedge clk);
    check("clr_drop_lost", lost, 1);
    check("clr_drop_level", fifo_level, 4);
    tick(4);
    capture_in = 1'b0;
    tick(2);
    clear_lost = 1'b1;
    tick(1);
    clear_lost = 1'b0;
    @(negedge clk);
    check("clr_alone_lost", lost, 0);

    wait_cnt(700);
    capture_in = 1'b1;
    wait_cnt(700 + L);
    cap_ready = 1'b1;
    tick(1);
    cap_ready = 1'b0;
    @(negedge clk);
    check("pp_level", fifo_level, 4);
    check("pp_lost", lost, 0);
    check("pp_head", cap_value, 610 + L);
    tick(4);
    capture_in = 1'b0;

    exp_drain = '{610 + L, 620 + L, 630 + L, 700 + L};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drain%0d_valid", k), cap_valid, 1);
      check($sformatf("drain%0d_value", k), cap_value, exp_drain[k]);
      check($sformatf("drain%0d_edge", k), cap_edge, 1);
      cap_ready = 1'b1;
      @(posedge clk);
      #1 cap_ready = 1'b0;
    end
    @(negedge clk);
    check("drain_level", fifo_level, 0);

    // Reset discards a pending entry; a line held high through reset is not captured.
    wait_cnt(760);
    capture_in = 1'b1;
    tick(8);
    @(negedge clk);
    check("mid_level", fifo_level, 1);
    check("mid_value", cap_value, 760 + L);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(4);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_level", fifo_level, 0);
    tick(12);
    @(negedge clk);
    check("arm_valid", cap_valid, 0);
    check("arm_level", fifo_level, 0);
    capture_in = 1'b0;
    tick(6);

    // Randomized traffic against the model.
    reset = 1'b1;
    tick(4);
    reset    = 1'b0;
    model_on = 1'b1;
    hold     = 10;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      cap_ready  = ($urandom_range(0, 4) < 2);
      clear_lost = ($urandom_range(0, 15) == 0);
      enable     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) edgeMode = 2'($urandom_range(0, 3));
      if (hold == 0) begin
        capture_in = ~capture_in;
        hold = $urandom_range(3, 8);
      end else begin
        hold--;
      end
    end
    @(negedge clk);
    model_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_capture.md
Name: count_capture

Overview:
- Input-capture unit, the reading end of the `count` timer.
- Watches an asynchronous external event line.
- On each selected edge, timestamps the event with the live timer value and buffers it in a small FIFO.
- Software or downstream logic drains the FIFO over a valid/ready interface; overruns are flagged.

Parameters:
COUNTER_SIZE, 32, width of timer value and captured timestamps
FIFO_DEPTH, 4, capture FIFO entries; power of 2, >= 2
SYNC_STAGES, 2, synchronizer flops on capture_in; >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = edges may be captured; 0 = edges ignored, FIFO still drains
edgeMode  input  2  00 none, 01 rising, 10 falling, 11 both
count_in  input  COUNTER_SIZE  live timer value from count.count
capture_in  input  1  asynchronous event line
cap_value  output  COUNTER_SIZE  timestamp at FIFO head
cap_edge  output  1  edge type at FIFO head: 1 rising, 0 falling
cap_valid  output  1  FIFO non-empty
cap_ready  input  1  consumer accepts head entry
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored entries
lost  output  1  sticky overrun flag
clear_lost  input  1  clears lost

Behaviour:
- Reset (synchronous, sampled on posedge clk):
  - sync chain = 0, prev level = 0, arm counter = 0, FIFO pointers = 0.
  - cap_valid = 0, fifo_level = 0, lost = 0, cap_value = 0, cap_edge = 0.
  - Reset mid-operation discards all FIFO contents.
- Synchronizer: capture_in passes through SYNC_STAGES flops; sync_out = last stage; prev = sync_out delayed 1 cycle.
- Arming:
  - Arm counter counts up after reset deasserts; saturates at SYNC_STAGES+1.
  - Edge detection is suppressed until saturation, so a high line at reset is not captured.
- Edge detect: in cycle k, sync_out != prev.
  - rising = sync_out & ~prev; falling = ~sync_out & prev.
  - Capture request = armed & enable & ((rising & edgeMode[0]) | (falling & edgeMode[1])).
- Capture:
  - {count_in sampled in cycle k, rising} is written at the end of cycle k; cap_valid is high in cycle k+1 if the FIFO was empty.
  - Latency: capture_in first sampled high at edge E0 → cap_value = count_in value after E1 (E0 + 2 clocks for SYNC_STAGES=2).
- FIFO:
  - Show-ahead; cap_value/cap_edge are valid whenever cap_valid = 1 and hold stable until popped.
  - Pop when cap_valid & cap_ready; cap_ready is ignored when empty.
  - Push and pop in the same cycle: level unchanged; allowed when full (the pop frees the slot).
  - Full with push and no pop: entry dropped, FIFO unchanged, lost <= 1.
- lost:
  - Sticky; clear_lost = 1 clears it next cycle.
  - clear_lost coincident with a new drop: lost stays 1 (set wins).
- enable or edgeMode change: takes effect in the same cycle; pending entries unaffected.
- Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- No arithmetic on count_in; timer wrap-around is the consumer's concern.

Optional Feature:
- Macro: COUNT_CAPTURE_FILTER_EN
- Defined:
  - Glitch filter between sync_out and edge detect.
  - Filtered level changes only after sync_out holds a new value for 3 consecutive cycles; pulses shorter than 3 cycles are ignored.
  - Adds 2 cycles of capture latency.
  - Filter state resets to 0; the arm count becomes SYNC_STAGES+3.
- Undefined: no filter; latency as above.

Test Plan:
- Setup for all scenarios: reset 4 cycles, count_in = free-running counter, edgeMode = 01, cap_ready = 1.
- Rising-edge capture: capture_in first sampled high when count_in goes 100→101 → one entry, cap_value = 102, cap_edge = 1; next cycle fifo_level returns to 0.
- Both edges: edgeMode = 11; rise at count 200, fall at count 250 → entries 202/rise then 252/fall, in order.
- Overrun: cap_ready = 0, FIFO_DEPTH = 4, five rising edges → fifo_level = 4, lost = 1, first four timestamps preserved in order.
- Clear vs. drop: clear_lost asserted in the same cycle as a further drop → lost stays 1; clear alone → lost = 0.
- Full with simultaneous push/pop: with FIFO full, pulse cap_ready for 1 cycle coincident with a new edge → level stays 4, lost stays 0, oldest entry removed.
- Reset/arming: capture_in held high through reset → no entry after release. enable = 0 during an edge → no entry.
- With COUNT_CAPTURE_FILTER_EN defined:
  - 2-cycle high pulse → no entry.
  - Clean rise at 100→101 → cap_value = 104.
